// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: instruction-memory latency calibration and I-cache line refill sequencer
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   miss_i            tag mismatch on a valid fetch, sampled in IDLE
//   pc_changed_i      fetch redirect, aborts an in-flight refill
//   mem_rdata_i       instruction memory read data
//   mem_cs_o/mem_we_o memory chip select / write enable (probe write only)
//   test_en_o         0 while this block owns the memory port for calibration
//   cache_wen_o       I-cache write enable, active-low
//   word_idx_o        word offset of the line being written
//   pc_src_o          select refill restart PC
//   imem_sel_o        instruction source is memory rather than cache
//   busy_o            high in every state except IDLE
//   cal_done_o        measured latency is valid
//   cal_err_o         calibration timed out, sticky until rst
//   latency_o         measured read latency
// Optional: define ICACHE_REFILL_PERF_EN to add saturating perf_miss_o / perf_stall_o counters.
module icache_refill_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                LAT_W       = 4,
  parameter int                LINE_WORDS  = 4,
  parameter logic [DATA_W-1:0] CAL_PATTERN = '1,
  parameter int                WAIT_CYC    = 13,
  localparam int               WI_W        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
  localparam int               WW          = (WAIT_CYC > 1) ? $clog2(WAIT_CYC + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_i,
  input  logic              pc_changed_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic              test_en_o,
  output logic              cache_wen_o,
  output logic [WI_W-1:0]   word_idx_o,
  output logic              pc_src_o,
  output logic              imem_sel_o,
  output logic              busy_o,
  output logic              cal_done_o,
  output logic              cal_err_o,
`ifdef ICACHE_REFILL_PERF_EN
  output logic [LAT_W-1:0]  latency_o,
  output logic [15:0]       perf_miss_o,
  output logic [15:0]       perf_stall_o
`else
  output logic [LAT_W-1:0]  latency_o
`endif
);
  typedef enum logic [3:0] {
    RST_S, CAL_WR, CAL_WAIT, CAL_RD, CAL_POLL, FAULT, IDLE, FETCH, FILL, RESTART
  } state_t;
  localparam logic [WI_W-1:0] LAST_IDX = WI_W'(LINE_WORDS - 1);
  state_t            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d, lat_q, lat_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [WI_W-1:0]   idx_q, idx_d;
  logic              done_q, done_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_S;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      lat_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    done_d  = done_q;
    case (state_q)
      RST_S: state_d = CAL_WR;
      CAL_WR: begin
        wcnt_d  = '0;
        state_d = CAL_WAIT;
      end
      CAL_WAIT: begin
        wcnt_d  = (wcnt_q == WW'(WAIT_CYC - 1)) ? wcnt_q : wcnt_q + 1'b1;
        state_d = (wcnt_q == WW'(WAIT_CYC - 1)) ? CAL_RD : CAL_WAIT;
      end
      CAL_RD: begin
        cnt_d   = '0;
        state_d = CAL_POLL;
      end
      // A match wins over the timeout so the last count value is still usable.
      CAL_POLL: begin
        if (mem_rdata_i == CAL_PATTERN) begin
          lat_d   = cnt_q;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '1) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FAULT: state_d = FAULT;
      IDLE: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = miss_i ? FETCH : IDLE;
      end
      FETCH: begin
        if (pc_changed_i) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == lat_q) begin
          cnt_d   = '0;
          state_d = FILL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // The word is written on this cycle even when aborted; only the rest of the line is dropped.
      FILL: begin
        cnt_d = '0;
        if (pc_changed_i) begin
          idx_d   = '0;
          state_d = IDLE;
        end else if (idx_q == LAST_IDX) begin
          state_d = RESTART;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end
      end
      RESTART: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = RST_S;
    endcase
  end
  logic cal_port;
  assign cal_port    = (state_q == CAL_WR) || (state_q == CAL_WAIT) || (state_q == CAL_RD) || (state_q == CAL_POLL);
  assign imem_sel_o  = (state_q == FETCH) || (state_q == FILL) || (state_q == RESTART);
  assign mem_cs_o    = imem_sel_o || (state_q == CAL_WR) || (state_q == CAL_RD) || (state_q == CAL_POLL);
  assign mem_we_o    = state_q == CAL_WR;
  assign test_en_o   = !cal_port;
  assign cache_wen_o = state_q != FILL;
  assign pc_src_o    = state_q == RESTART;
  assign busy_o      = state_q != IDLE;
  assign cal_err_o   = state_q == FAULT;
  assign cal_done_o  = done_q;
  assign latency_o   = lat_q;
  assign word_idx_o  = idx_q;
`ifdef ICACHE_REFILL_PERF_EN
  logic [15:0] pmiss_q, pstall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmiss_q  <= '0;
      pstall_q <= '0;
    end else begin
      pmiss_q  <= (state_q == IDLE && miss_i && pmiss_q != 16'hFFFF) ? pmiss_q + 16'd1 : pmiss_q;
      pstall_q <= (imem_sel_o && pstall_q != 16'hFFFF) ? pstall_q + 16'd1 : pstall_q;
    end
  end
  assign perf_miss_o  = pmiss_q;
  assign perf_stall_o = pstall_q;
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: scoreboard bench for icache_refill_ctrl (calibration, refill, abort, reset, fault)
module tb_icache_refill_ctrl;
  localparam int LW = 4;
  logic        clk = 1'b0, rst = 1'b1, miss_i = 1'b0, pc_changed_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_cs_o, mem_we_o, test_en_o, cache_wen_o, pc_src_o, imem_sel_o, busy_o, cal_done_o, cal_err_o;
  logic [1:0]  word_idx_o;
  logic [3:0]  latency_o;
`ifdef ICACHE_REFILL_PERF_EN
  logic [15:0] perf_miss_o, perf_stall_o;
`endif
  icache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_i(miss_i), .pc_changed_i(pc_changed_i), .mem_rdata_i(mem_rdata_i),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .test_en_o(test_en_o), .cache_wen_o(cache_wen_o),
    .word_idx_o(word_idx_o), .pc_src_o(pc_src_o), .imem_sel_o(imem_sel_o), .busy_o(busy_o),
    .cal_done_o(cal_done_o), .cal_err_o(cal_err_o),
`ifdef ICACHE_REFILL_PERF_EN
    .latency_o(latency_o), .perf_miss_o(perf_miss_o), .perf_stall_o(perf_stall_o)
`else
    .latency_o(latency_o)
`endif
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int exp_cyc[$], exp_idx[$], exp_rs[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [8:0] ctl();
    return {mem_cs_o, mem_we_o, test_en_o, cache_wen_o, pc_src_o, imem_sel_o, busy_o, cal_done_o, cal_err_o};
  endfunction
  // Monitor: every cache write and restart pulse is matched against the scoreboard queues.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (!rst) begin
      if (!cache_wen_o) begin
        if (exp_cyc.size() == 0) check("unexp_write", cache_wen_o, 1);
        else begin
          check("wr_cyc", cyc, exp_cyc.pop_front());
          check("wr_idx", word_idx_o, exp_idx.pop_front());
        end
      end
      if (pc_src_o) begin
        if (exp_rs.size() == 0) check("unexp_restart", pc_src_o, 0);
        else check("rs_cyc", cyc, exp_rs.pop_front());
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic calibrate(input int lat);
    rst = 1'b1; miss_i = 1'b0; pc_changed_i = 1'b0; mem_rdata_i = '0;
    exp_cyc.delete(); exp_idx.delete(); exp_rs.delete();
    @(negedge clk);
    check("rst_ctl", ctl(), 9'b001100100);
    check("rst_lat", latency_o, 0);
    check("rst_idx", word_idx_o, 0);
    rst = 1'b0;
    for (int n = 1; n <= 16 + lat; n++) begin
      @(negedge clk);
      if (n == 1) check("cal_wr", {mem_cs_o, mem_we_o, test_en_o}, 3'b110);
      if (n == 14) check("cal_wait_cs", mem_cs_o, 0);
      if (n == 15) check("cal_rd", {mem_cs_o, mem_we_o, test_en_o}, 3'b100);
      if (n == 16 + lat) begin
        check("cal_poll_busy", busy_o, 1);
        mem_rdata_i = 32'hFFFF_FFFF;
      end
    end
    @(negedge clk);
    mem_rdata_i = '0;
    check("cal_idle", busy_o, 0);
    check("cal_done", cal_done_o, 1);
    check("cal_lat", latency_o, lat);
  endtask
  task automatic do_miss(input int lat);
    int c;
    c = cyc;
    for (int w = 0; w < LW; w++) begin
      exp_cyc.push_back(c + (w + 1) * (lat + 2));
      exp_idx.push_back(w);
    end
    exp_rs.push_back(c + LW * (lat + 2) + 1);
    miss_i = 1'b1;
    @(negedge clk);
    miss_i = 1'b0;
    check("fetch_entry", {busy_o, mem_cs_o, imem_sel_o, test_en_o}, 4'b1111);
    repeat (LW * (lat + 2)) @(negedge clk);
    @(negedge clk);
    check("refill_idle", busy_o, 0);
    check("refill_idx", word_idx_o, 0);
    check("refill_pending", exp_cyc.size() + exp_rs.size(), 0);
  endtask
  initial begin
    int c;
    calibrate(2);
    repeat (3) do_miss(2);
`ifdef ICACHE_REFILL_PERF_EN
    check("perf_miss", perf_miss_o, 3);
    check("perf_stall", perf_stall_o, 51);
`endif
    // abort during the second FETCH: only word 0 lands, no restart
    c = cyc;
    exp_cyc.push_back(c + 4);
    exp_idx.push_back(0);
    miss_i = 1'b1;
    @(negedge clk);
    miss_i = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_fetch_idx", {imem_sel_o, word_idx_o}, 3'b101);
    pc_changed_i = 1'b1;
    @(negedge clk);
    pc_changed_i = 1'b0;
    check("abort_idle", busy_o, 0);
    check("abort_idx", word_idx_o, 0);
    repeat (3) @(negedge clk);
    check("abort_pending", exp_cyc.size() + exp_rs.size(), 0);
    do_miss(2);
    // asynchronous reset during FILL of word 1
    c = cyc;
    exp_cyc.push_back(c + 4); exp_idx.push_back(0);
    exp_cyc.push_back(c + 8); exp_idx.push_back(1);
    miss_i = 1'b1;
    @(negedge clk);
    miss_i = 1'b0;
    repeat (7) @(negedge clk);
    check("fill_pre_rst", {cache_wen_o, word_idx_o}, 3'b001);
    #1 rst = 1'b1;
    #1;
    check("async_rst_ctl", ctl(), 9'b001100100);
    check("async_rst_idx", word_idx_o, 0);
    check("fill_pending", exp_cyc.size(), 0);
    calibrate(0);
    do_miss(0);
    // calibration timeout
    rst = 1'b1; mem_rdata_i = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (31) @(negedge clk);
    check("poll_last", {busy_o, cal_err_o, mem_cs_o}, 3'b101);
    @(negedge clk);
    check("fault", {busy_o, cal_err_o, cal_done_o, mem_cs_o, test_en_o}, 5'b11001);
    miss_i = 1'b1;
    repeat (5) @(negedge clk);
    miss_i = 1'b0;
    check("fault_sticky", {busy_o, cal_err_o, imem_sel_o}, 3'b110);
    rst = 1'b1;
    #1;
    check("fault_rst", ctl(), 9'b001100100);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("fault_recal", {mem_we_o, test_en_o}, 2'b10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
